dmem_ctrl: RTL
==============

Name: dmem_ctrl

Overview:
- Parametrised data-memory controller with a valid/ready request and response handshake, configurable wait states, and byte/halfword/word access.
- Sign- or zero-extended sub-word loads, little-endian byte lanes, misalignment detection.
- Sits between the multi-cycle CPU's memory stage and a synchronous single-port word array held inside the block.

Parameters:
ADDR_WIDTH, 12, byte-address width; the array holds 2^(ADDR_WIDTH-2) 32-bit words, indexed by Address[ADDR_WIDTH-1:2].
WAIT_STATES, 2, idle cycles inserted between accept and access (0 legal).

Ports:
Clk  in  1  clock; all state changes on posedge.
Reset_n  in  1  asynchronous, active-low reset.
ReqValid  in  1  request present.
ReqReady  out  1  controller can accept; equals (state==IDLE).
ReqWrite  in  1  1=store, 0=load.
ReqSize  in  2  00 byte, 01 half, 10 word, 11 reserved.
ReqSigned  in  1  loads only: 1 sign-extend, 0 zero-extend.
Address  in  ADDR_WIDTH  byte address.
WriteData  in  32  store data, right-justified for byte/half.
RespValid  out  1  response present.
RespReady  in  1  consumer takes response.
RespData  out  32  load result; 0 for stores and errors.
RespError  out  1  misaligned or reserved-size request.
Busy  out  1  state != IDLE.

Behaviour:
- Reset (async, Reset_n=0): state=IDLE, wait counter=0, RespValid=0, RespData=0, RespError=0.
  - ReqReady=1 and Busy=0 while in reset.
  - Array contents not reset (X until written).
  - Reset mid-operation aborts; a store not yet performed is dropped.
- States: IDLE, WAIT, RESP.
- IDLE: on a posedge with ReqValid&ReqReady, capture ReqWrite, ReqSize, ReqSigned, Address and WriteData.
  - Error request: ReqSize==11, half with Address[0]=1, or word with Address[1:0]!=0.
    - Go to RESP with RespError=1 and RespData=0.
    - No array access; the response appears one edge after accept regardless of WAIT_STATES.
  - Valid request:
    - WAIT_STATES>0: go to WAIT and load the counter with WAIT_STATES-1.
    - WAIT_STATES=0: access immediately.
- WAIT: decrement the counter each cycle. When it is 0, perform the access on that edge and go to RESP.
- Access edge: RespValid=1 after the edge. Accept-to-RespValid latency is exactly WAIT_STATES+1 edges.
- Store, lane k=Address[1:0]:
  - Byte writes bits[8k+7:8k] from WriteData[7:0].
  - Half writes bits[16h+15:16h] from WriteData[15:0], with h=Address[1].
  - Word writes all 32 bits.
  - Other lanes are untouched (read-modify-write internally, or per-byte arrays).
  - RespData=0.
- Load: select the same lanes, then extend to 32 bits per ReqSigned. Word loads ignore ReqSigned.
- RESP: RespValid, RespData and RespError are held stable until a posedge with RespReady=1, then go to IDLE.
  - On that edge, clear RespValid, RespError and RespData.
  - ReqReady rises the cycle after the response is taken. There is no accept in the same cycle as the response handshake.
- ReqValid while not ready is ignored. Inputs are not sampled outside the accept edge.
- The counter is sized to hold WAIT_STATES.

Test Plan:
1. WAIT_STATES=2: word store 0xDEADBEEF @0x010, then word load @0x010 → RespData=0xDEADBEEF; RespValid exactly 3 edges after each accept; Busy high throughout.
2. Word store 0x00000000 @0x010; byte store 0x80 @0x013 → signed byte load @0x013 returns 0xFFFFFF80, unsigned 0x00000080, word load @0x010 returns 0x80000000.
3. Half store 0x8001 @0x012 → signed half load 0xFFFF8001, unsigned 0x00008001; word load @0x010 keeps the low half 0x0000.
4. Word load @0x011, half store @0x011, size 11 @0x000 → RespError=1, RespData=0 one edge after accept; subsequent word load @0x010 shows memory unchanged.
5. RespReady low for 5 cycles after RespValid → RespValid/RespData stable, ReqReady=0, ReqValid pulses ignored; RespReady=1 → IDLE the next edge.
6. Reset_n pulsed low in WAIT of a store @0x020 → outputs clear immediately, ReqReady=1; the store is not performed. Repeat case 1 with WAIT_STATES=0 → latency 1 edge.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request/response handshake in front of an
// internal word array, with programmable wait states and byte/half/word lanes.
module dmem_ctrl #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 2
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [1:0]            ReqSize,
    input  logic                  ReqSigned,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           WriteData,
    output logic                  RespValid,
    input  logic                  RespReady,
    output logic [31:0]           RespData,
    output logic                  RespError,
    output logic                  Busy
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic logic req_is_err(input logic [1:0] size, input logic [1:0] lo);
        logic e;
        case (size)
            2'b00:   e = 1'b0;
            2'b01:   e = lo[0];
            2'b10:   e = (lo != 2'b00);
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] old_w, input logic [31:0] wd,
                                                input logic [1:0] size, input logic [1:0] lo);
        logic [31:0] m;
        m = old_w;
        case (size)
            2'b00:   m[{lo, 3'b000} +: 8]         = wd[7:0];
            2'b01:   m[{lo[1], 4'b0000} +: 16]    = wd[15:0];
            2'b10:   m                            = wd;
            default: m                            = old_w;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] size,
                                                 input logic [1:0] lo, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{lo, 3'b000} +: 8];
        h = w[{lo[1], 4'b0000} +: 16];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            2'b10:   r = w;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    logic [31:0]           mem [DEPTH];

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  rvalid_q, rvalid_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rerr_q, rerr_d;

    logic                  acc_s;
    logic                  acc_write_s;
    logic [1:0]            acc_size_s;
    logic                  acc_signed_s;
    logic [ADDR_WIDTH-1:0] acc_addr_s;
    logic [31:0]           acc_wdata_s;
    logic [31:0]           mem_rd_s;
    logic [31:0]           acc_rdata_s;
    logic [31:0]           mem_wr_s;
    logic                  mem_we_s;
    logic                  accept_s;
    logic                  err_in_s;

    assign accept_s = ReqValid & (state_q == S_IDLE);
    assign err_in_s = req_is_err(ReqSize, Address[1:0]);

    // Access operands: live inputs when accessing on the accept edge, captured copy otherwise.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_write_s  = ReqWrite;
            acc_size_s   = ReqSize;
            acc_signed_s = ReqSigned;
            acc_addr_s   = Address;
            acc_wdata_s  = WriteData;
        end else begin
            acc_write_s  = write_q;
            acc_size_s   = size_q;
            acc_signed_s = signed_q;
            acc_addr_s   = addr_q;
            acc_wdata_s  = wdata_q;
        end
    end

    // Lane read, store merge and load response value for the current access.
    always_comb begin
        mem_rd_s    = mem[acc_addr_s[ADDR_WIDTH-1:2]];
        mem_wr_s    = merge_store(mem_rd_s, acc_wdata_s, acc_size_s, acc_addr_s[1:0]);
        acc_rdata_s = acc_write_s ? 32'h0000_0000
                                  : load_extract(mem_rd_s, acc_size_s, acc_addr_s[1:0], acc_signed_s);
    end

    // Next-state and response logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;
        acc_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    write_d  = ReqWrite;
                    size_d   = ReqSize;
                    signed_d = ReqSigned;
                    addr_d   = Address;
                    wdata_d  = WriteData;
                    if (err_in_s) begin
                        state_d  = S_RESP;
                        rvalid_d = 1'b1;
                        rerr_d   = 1'b1;
                        rdata_d  = 32'h0000_0000;
                    end else if (WAIT_STATES == 0) begin
                        acc_s    = 1'b1;
                        state_d  = S_RESP;
                        rvalid_d = 1'b1;
                        rerr_d   = 1'b0;
                        rdata_d  = acc_rdata_s;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    acc_s    = 1'b1;
                    state_d  = S_RESP;
                    rvalid_d = 1'b1;
                    rerr_d   = 1'b0;
                    rdata_d  = acc_rdata_s;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (RespReady) begin
                    state_d  = S_IDLE;
                    rvalid_d = 1'b0;
                    rerr_d   = 1'b0;
                    rdata_d  = 32'h0000_0000;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d  = S_IDLE;
                rvalid_d = 1'b0;
                rerr_d   = 1'b0;
                rdata_d  = 32'h0000_0000;
            end
        endcase
    end

    // Gated by Reset_n so nothing reaches the array while reset is asserted.
    assign mem_we_s = acc_s & acc_write_s & Reset_n;

    // Control and response registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            write_q  <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= {ADDR_WIDTH{1'b0}};
            wdata_q  <= 32'h0000_0000;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0000_0000;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
        end
    end

    // Word array write port; contents are intentionally not reset.
    always_ff @(posedge Clk) begin
        if (mem_we_s) begin
            mem[acc_addr_s[ADDR_WIDTH-1:2]] <= mem_wr_s;
        end
    end

    assign ReqReady  = (state_q == S_IDLE);
    assign Busy      = (state_q != S_IDLE);
    assign RespValid = rvalid_q;
    assign RespData  = rdata_q;
    assign RespError = rerr_q;

endmodule
